// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared CONV-unit definitions used by the output partial-sum FIFO and its
// interface.
//   PSUM_W       - native partial-sum element width
//   psum_t       - one partial-sum element
//   psum_pair_t  - two packed elements, lo is the older one
//   pop_mod_e    - pop granularity selector (single element / packed pair)
// ---------------------------------------------------------------------------
package conv_pkg;

   localparam int PSUM_W = 16;

   typedef logic [PSUM_W-1:0] psum_t;

   typedef struct packed {
      psum_t hi;
      psum_t lo;
   } psum_pair_t;

   typedef enum logic {
      POP_SINGLE = 1'b0,
      POP_PAIR   = 1'b1
   } pop_mod_e;

endpackage : conv_pkg

// File: rtl/opsum_fifo_if.sv
// ---------------------------------------------------------------------------
// opsum_fifo_if
// Push/pop bundle of the output partial-sum FIFO.
//   push_en, push_data        - producer side (PE/accumulator)
//   pop_en, pop_mod           - consumer request (output buffer write port)
//   pop_data, pop_valid       - registered pop result
//   full, empty, pair_avail,
//   count                     - occupancy status
// Modports:
//   master - the side that pushes/pops (drives requests, sees status)
//   slave  - the FIFO itself
// ---------------------------------------------------------------------------
interface opsum_fifo_if
   import conv_pkg::*;
#(
   parameter int WIDTH = PSUM_W,
   parameter int DEPTH = 8
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic               push_en;
   logic [WIDTH-1:0]   push_data;
   logic               full;
   logic               pop_en;
   pop_mod_e           pop_mod;
   logic [2*WIDTH-1:0] pop_data;
   logic               pop_valid;
   logic               empty;
   logic               pair_avail;
   logic [CW-1:0]      count;

   modport master (
      output push_en,
      output push_data,
      output pop_en,
      output pop_mod,
      input  full,
      input  pop_data,
      input  pop_valid,
      input  empty,
      input  pair_avail,
      input  count
   );

   modport slave (
      input  push_en,
      input  push_data,
      input  pop_en,
      input  pop_mod,
      output full,
      output pop_data,
      output pop_valid,
      output empty,
      output pair_avail,
      output count
   );

endinterface : opsum_fifo_if

// File: rtl/opsum_fifo.sv
// ---------------------------------------------------------------------------
// opsum_fifo
// Output partial-sum FIFO of the CONV unit. Accepts one WIDTH-bit psum per
// push and drains either one element per pop (zero-extended into pop_data)
// or two elements packed into one 2*WIDTH word, older element in the low
// half. Pop results are registered and appear one cycle after acceptance.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   bus        - opsum_fifo_if.slave (push/pop handshake and status)
//   ovf_err    - sticky: push attempted while full      (OPSUM_FIFO_ERR_EN)
//   udf_err    - sticky: pop attempted and rejected     (OPSUM_FIFO_ERR_EN)
//
// Build option:
//   OPSUM_FIFO_ERR_EN - when defined, adds the ovf_err/udf_err outputs.
//                       When undefined, illegal requests are silently dropped.
//
// Parameters:
//   WIDTH - psum element width
//   DEPTH - number of entries, power of two, >= 2
// ---------------------------------------------------------------------------
module opsum_fifo
   import conv_pkg::*;
#(
   parameter int WIDTH = PSUM_W,
   parameter int DEPTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   opsum_fifo_if.slave   bus
`ifdef OPSUM_FIFO_ERR_EN
   ,
   output logic          ovf_err,
   output logic          udf_err
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [WIDTH-1:0]   mem [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] pop_data_q;
   logic               pop_valid_q;

   // ------------------------------------------------------------------
   // Status decodes of the count register
   // ------------------------------------------------------------------
   logic full_i;
   logic empty_i;
   logic pair_avail_i;

   assign full_i       = (cnt == CW'(DEPTH));
   assign empty_i      = (cnt == '0);
   assign pair_avail_i = (cnt >= CW'(2));

   // ------------------------------------------------------------------
   // Request acceptance, all judged on the count at the start of the cycle
   // ------------------------------------------------------------------
   logic          push_acc;
   logic          pop_single;
   logic          pop_pair;
   logic          pop_acc;
   logic [1:0]    pop_n;
   logic [AW-1:0] rd_ptr_p1;
   logic [CW-1:0] count_next;

   // A push while full is dropped even when a pop frees a slot this cycle.
   assign push_acc   = bus.push_en && !full_i;
   assign pop_single = bus.pop_en && (bus.pop_mod == POP_SINGLE) && !empty_i;
   assign pop_pair   = bus.pop_en && (bus.pop_mod == POP_PAIR)   && pair_avail_i;
   assign pop_acc    = pop_single || pop_pair;

   // Pointer arithmetic wraps naturally at the power-of-two depth, so a
   // pair straddling the last and first entries needs no special case.
   assign rd_ptr_p1  = rd_ptr + 1'b1;

   always_comb begin
      pop_n = 2'd0;
      if (pop_pair) begin
         pop_n = 2'd2;
      end else if (pop_single) begin
         pop_n = 2'd1;
      end
   end

   assign count_next = cnt + CW'(push_acc) - CW'(pop_n);

   // ------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------
   // NOTE: the storage array is deliberately left out of reset; its contents
   // are don't-care after reset and a reset here would force flops instead
   // of a RAM-style array.
   always_ff @(posedge clk) begin
      if (push_acc) begin
         mem[wr_ptr] <= bus.push_data;
      end
   end

   // ------------------------------------------------------------------
   // Pointers, count and registered pop result
   // ------------------------------------------------------------------
   // NOTE: every register in this design is updated with non-blocking
   // assignments so all reads in a cycle see the start-of-cycle state; this
   // is what keeps a same-cycle push from being visible to a pop (no bypass).
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         cnt         <= '0;
         pop_data_q  <= '0;
         pop_valid_q <= 1'b0;
      end else begin
         if (push_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         rd_ptr      <= rd_ptr + AW'(pop_n);
         cnt         <= count_next;
         pop_valid_q <= pop_acc;
         // pop_data holds its last value when nothing is popped.
         if (pop_pair) begin
            pop_data_q <= {mem[rd_ptr_p1], mem[rd_ptr]};
         end else if (pop_single) begin
            pop_data_q <= {{WIDTH{1'b0}}, mem[rd_ptr]};
         end
      end
   end

   // ------------------------------------------------------------------
   // Optional sticky error flags
   // ------------------------------------------------------------------
`ifdef OPSUM_FIFO_ERR_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_err <= 1'b0;
         udf_err <= 1'b0;
      end else begin
         if (bus.push_en && full_i) begin
            ovf_err <= 1'b1;
         end
         if (bus.pop_en && !pop_acc) begin
            udf_err <= 1'b1;
         end
      end
   end
`endif

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.full       = full_i;
   assign bus.empty      = empty_i;
   assign bus.pair_avail = pair_avail_i;
   assign bus.count      = cnt;
   assign bus.pop_data   = pop_data_q;
   assign bus.pop_valid  = pop_valid_q;

endmodule : opsum_fifo

// File: doc/opsum_fifo.md
Name: opsum_fifo

Overview:
- Output partial-sum FIFO inside the CONV unit. Collects 16-bit psums from the PE/accumulator one entry per push.
- Drains toward the output buffer write port either one 16-bit entry per pop, or a packed 32-bit word of two entries per pop.
- Mirror of the input-psum path: single push in, selectable single/burst pop out.

Parameters:
- WIDTH, 16, psum element width in bits; pop_data is 2*WIDTH wide.
- DEPTH, 8, number of entries; power of two and at least 2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- push_en  input  1  push one element this cycle.
- push_data  input  WIDTH  element to push.
- full  output  1  count == DEPTH.
- pop_en  input  1  pop request this cycle.
- pop_mod  input  1  0: pop 1 entry; 1: pop 2 entries packed.
- pop_data  output  2*WIDTH  registered pop result.
- pop_valid  output  1  pulses one cycle after an accepted pop.
- empty  output  1  count == 0.
- pair_avail  output  1  count >= 2; a burst pop would be accepted.
- count  output  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Reset (rst=1 at a clock edge):
  - wr_ptr, rd_ptr and count go to 0.
  - pop_data goes to 0 and pop_valid to 0.
  - empty=1, full=0, pair_avail=0.
  - Storage contents are don't-care.
  - Reset mid-operation discards all entries; no pop_valid is issued for a pop requested in the reset cycle.
- Push accepted: push_en && !full, using the count at the start of the cycle.
  - Writes mem[wr_ptr] and advances wr_ptr by 1, modulo DEPTH.
  - Push while full is dropped, even if a pop is accepted in the same cycle.
- Single pop (pop_mod=0) accepted: pop_en && !empty.
  - Cycle N+1: pop_data[WIDTH-1:0] = mem[rd_ptr], upper half = 0, pop_valid=1.
  - rd_ptr advances by 1.
- Burst pop (pop_mod=1) accepted: pop_en && pair_avail.
  - Cycle N+1: pop_data[WIDTH-1:0] = mem[rd_ptr] (older entry), pop_data[2*WIDTH-1:WIDTH] = mem[rd_ptr+1], pop_valid=1.
  - rd_ptr advances by 2, modulo DEPTH.
  - Pointer wrap in mid-pair is legal; for example, entries 7 and 0 pack correctly with DEPTH=8.
- Rejected pop (empty, or burst with count<2): no state change, pop_valid=0.
- When no pop is accepted, pop_data holds its previous value and pop_valid=0.
- Count update, each cycle: count_next = count + push_acc - pop_n, where pop_n is 0, 1 or 2.
  - Simultaneous accepted push and pop are both performed.
  - A pop never returns the element pushed in the same cycle (no bypass), so minimum fall-through latency is 2 cycles.
- Ordering: strict FIFO; lower half of a packed word is always the older element.
- full, empty, pair_avail and count are combinational decodes of the count register.

Optional Feature:
- Macro: OPSUM_FIFO_ERR_EN.
- When defined, adds two outputs:
  - ovf_err (1 bit): sticky, set by push_en while full.
  - udf_err (1 bit): sticky, set by pop_en with a rejected pop.
  - Both clear only on rst.
- When not defined, the ports do not exist and illegal requests are silently ignored as described above.

Decomposition:
- Shared package conv_pkg holds:
  - PSUM_W = 16.
  - typedef psum_t (logic [PSUM_W-1:0]).
  - typedef psum_pair_t (packed struct {psum_t hi; psum_t lo;}).
  - typedef enum pop_mod_e {POP_SINGLE=0, POP_PAIR=1}.
- No sub-module needed. Storage, pointers and count fit in one module; the read mux for the pair (rd_ptr, rd_ptr+1) is inline.

Test Plan:
- Reset, then push 0x0011, 0x0022, 0x0033, then pop_mod=0 three times.
  - Required: pop_data 0x00000011, 0x00000022, 0x00000033 on consecutive cycles after each pop.
  - Required: pop_valid high each cycle; empty=1 afterwards.
- Push 0xAAAA, 0xBBBB, then burst pop.
  - Required: pop_data 0xBBBBAAAA next cycle, count 2→0.
  - Burst pop with count=1 is rejected: pop_valid=0, count stays 1, udf_err=1 if OPSUM_FIFO_ERR_EN is defined.
- Fill with 8 pushes (0x0100..0x0107).
  - Required: full=1.
  - A 9th push (0xDEAD) together with a single pop returns 0x0100; count goes to 7; 0xDEAD is never popped; ovf_err=1 if the macro is defined.
- Wrap: push 7, pop 7 single, then push 0x1234, 0x5678 and burst pop.
  - Pair occupies entries 7 and 0.
  - Required: pop_data 0x56781234.
- Simultaneous push and single pop every cycle for 20 cycles from count=3.
  - Required: count stays 3; output order is exactly the input order delayed by 3 entries.
- Assert rst while count=5 and a pop is requested.
  - Required next cycle: count=0, empty=1, pop_valid=0, pop_data=0.
